// File: rtl/cook_timer.sv
// ---------------------------------------------------------------------------
// cook_timer
//
// Microwave cook-time controller. Sits downstream of clockdiv100 and samples
// its 1 Hz clk_out as an ordinary level on the system clock; every rising edge
// of that level is one elapsed second.
//
// Keypad digits shift into an MM:SS BCD register. While cooking, the register
// counts down once per second. The seconds field may hold tens up to 9, so an
// entry such as 00:90 means ninety seconds. When the countdown reaches 00:00 a
// one-cycle done pulse is issued, and the beeper then sounds for BEEP_TICKS
// seconds.
//
// Parameters
//   BEEP_TICKS   number of 1 Hz tick edges the beeper stays on
//   QUICK_SECS   BCD seconds loaded by start from IDLE with an empty entry
//
// Ports
//   clk          in   system clock (same clock that feeds clockdiv100)
//   rst_n        in   asynchronous active-low reset
//   tick_in      in   clockdiv100 clk_out level; rising edge = one second
//   digit_valid  in   single-cycle strobe, keypad digit present
//   digit        in   keypad digit; values above 9 are ignored
//   start        in   single-cycle start/resume request
//   pause        in   single-cycle pause request
//   cancel       in   single-cycle cancel request
//   door_open    in   door switch level, 1 = open
//   min_tens     out  BCD display digit M1
//   min_ones     out  BCD display digit M0
//   sec_tens     out  BCD display digit S1 (0-9 during entry)
//   sec_ones     out  BCD display digit S0
//   mag_on       out  magnetron enable, high only while cooking
//   done         out  one-cycle pulse when the countdown reaches 00:00
//   beep         out  beeper enable, high only while beeping
//   state        out  IDLE=0 ENTRY=1 RUN=2 PAUSE=3 BEEP=4
// ---------------------------------------------------------------------------
module cook_timer #(
    parameter int         BEEP_TICKS = 3,
    parameter logic [7:0] QUICK_SECS = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        BEEP  = 3'd4
    } state_t;

    // Value of the beep counter on the tick that ends the beep phase.
    localparam logic [7:0] BEEP_LAST = 8'(BEEP_TICKS - 1);

    state_t      st;
    logic        tick_q;
    logic        tick_rise;
    logic [7:0]  beep_cnt;
    logic [15:0] cur_time;
    logic [15:0] dec_next;
    logic        time_zero;
    logic        digit_ok;

    // One-second countdown on a packed {M1,M0,S1,S0} BCD value.
    // Seconds tens may be anywhere in 0-9 (from keypad entry), so a borrow
    // from S1 only ever happens once S1 itself is 0; a borrow from the
    // minutes reloads the seconds to 59, never 99.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else if (s1 != 4'd0) begin
            s0 = 4'd9;
            s1 = s1 - 4'd1;
        end else if ((m1 != 4'd0) || (m0 != 4'd0)) begin
            s1 = 4'd5;
            s0 = 4'd9;
            if (m0 != 4'd0) begin
                m0 = m0 - 4'd1;
            end else begin
                m0 = 4'd9;
                m1 = m1 - 4'd1;
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    assign cur_time  = {min_tens, min_ones, sec_tens, sec_ones};
    assign dec_next  = dec_time(cur_time);
    assign time_zero = (cur_time == 16'h0000);
    assign tick_rise = tick_in & ~tick_q;
    assign digit_ok  = digit_valid && (digit <= 4'd9);
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            mag_on   <= 1'b0;
            done     <= 1'b0;
            beep     <= 1'b0;
            tick_q   <= 1'b0;
            beep_cnt <= 8'd0;
        end else begin
            tick_q <= tick_in;
            done   <= 1'b0;

            case (st)
                // Entry phase: cancel > (door only gates start) > start > digit.
                IDLE, ENTRY: begin
                    if (cancel) begin
                        st <= IDLE;
                        {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                    end else if (start) begin
                        // A start request owns the cycle even when it is
                        // refused (door open, or an empty ENTRY).
                        if (!door_open) begin
                            if (!time_zero) begin
                                st     <= RUN;
                                mag_on <= 1'b1;
                            end else if (st == IDLE) begin
                                {min_tens, min_ones} <= 8'h00;
                                {sec_tens, sec_ones} <= QUICK_SECS;
                                st     <= RUN;
                                mag_on <= 1'b1;
                            end
                        end
                    end else if (digit_ok) begin
                        // Shift left; the old M1 falls off the top.
                        min_tens <= min_ones;
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= digit;
                        st       <= ENTRY;
                    end
                end

                // Cooking. Any stop request wins over a coincident tick, so
                // the displayed time is exactly what will resume.
                RUN: begin
                    if (cancel || door_open || pause) begin
                        st     <= PAUSE;
                        mag_on <= 1'b0;
                    end else if (tick_rise) begin
                        {min_tens, min_ones, sec_tens, sec_ones} <= dec_next;
                        if (dec_next == 16'h0000) begin
                            st       <= BEEP;
                            mag_on   <= 1'b0;
                            done     <= 1'b1;
                            beep     <= 1'b1;
                            beep_cnt <= 8'd0;
                        end
                    end
                end

                // Held: only cancel or a door-closed start leave this state.
                PAUSE: begin
                    if (cancel) begin
                        st <= IDLE;
                        {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                    end else if (start && !door_open) begin
                        st     <= RUN;
                        mag_on <= 1'b1;
                    end
                end

                // Beeping for BEEP_TICKS one-second ticks; display stays 00:00.
                BEEP: begin
                    if (cancel) begin
                        st       <= IDLE;
                        beep     <= 1'b0;
                        beep_cnt <= 8'd0;
                        {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                    end else if (tick_rise) begin
                        if (beep_cnt >= BEEP_LAST) begin
                            st       <= IDLE;
                            beep     <= 1'b0;
                            beep_cnt <= 8'd0;
                        end else begin
                            beep_cnt <= beep_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    st       <= IDLE;
                    mag_on   <= 1'b0;
                    beep     <= 1'b0;
                    beep_cnt <= 8'd0;
                    {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       digit_valid;
    logic [3:0] digit;
    logic       start;
    logic       pause;
    logic       cancel;
    logic       door_open;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;
    logic       beep;
    logic [2:0] state;

    int tests;
    int fails;

    cook_timer #(
        .BEEP_TICKS(3),
        .QUICK_SECS(8'h30)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .digit_valid(digit_valid),
        .digit      (digit),
        .start      (start),
        .pause      (pause),
        .cancel     (cancel),
        .door_open  (door_open),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .mag_on     (mag_on),
        .done       (done),
        .beep       (beep),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    // One full second: rising edge seen on the first clock, low on the second.
    task automatic tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        tick_in     = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        start       = 1'b0;
        pause       = 1'b0;
        cancel      = 1'b0;
        door_open   = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_disp", disp(), 16'h0000);
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_outs", 16'({mag_on, done, beep}), 16'd0);
        rst_n = 1'b1;
        step();

        // Out-of-range digit ignored
        key(4'd12);
        chk("bad_digit_state", 16'(state), 16'd0);
        chk("bad_digit_disp", disp(), 16'h0000);

        // 1: keys 1,2,5 -> 01:25, 10 ticks -> 01:15
        key(4'd1);
        chk("entry_state", 16'(state), 16'd1);
        key(4'd2);
        key(4'd5);
        chk("entry_disp", disp(), 16'h0125);
        press_start();
        chk("t1_run_state", 16'(state), 16'd2);
        chk("t1_run_mag", 16'(mag_on), 16'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_mag_during", 16'(mag_on), 16'd1);
        end
        chk("t1_disp_after10", disp(), 16'h0115);
        press_cancel();
        chk("t1_cancel_pause", 16'(state), 16'd3);
        press_cancel();
        chk("t1_cancel_idle", disp(), 16'h0000);

        // 2: 00:01 -> done pulse, BEEP for 3 ticks
        key(4'd1);
        press_start();
        tick_in = 1'b1;
        step();
        chk("t2_done_pulse", 16'(done), 16'd1);
        chk("t2_beep_state", 16'(state), 16'd4);
        chk("t2_beep_on", 16'(beep), 16'd1);
        chk("t2_mag_off", 16'(mag_on), 16'd0);
        tick_in = 1'b0;
        step();
        chk("t2_done_one_cycle", 16'(done), 16'd0);
        tick();
        tick();
        chk("t2_beep_still", 16'({state, beep}), 16'({3'd4, 1'b1}));
        tick();
        chk("t2_beep_end", 16'({state, beep}), 16'({3'd0, 1'b0}));
        chk("t2_disp_zero", disp(), 16'h0000);

        // 3a: 01:00 -> 00:59
        key(4'd1);
        key(4'd0);
        key(4'd0);
        press_start();
        tick();
        chk("t3_min_borrow", disp(), 16'h0059);
        press_cancel();
        press_cancel();

        // 3b: 00:90 -> 00:89 -> 00:79
        key(4'd9);
        key(4'd0);
        chk("t3_entry_90", disp(), 16'h0090);
        press_start();
        tick();
        chk("t3_dec_89", disp(), 16'h0089);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_dec_79", disp(), 16'h0079);
        press_cancel();
        press_cancel();

        // Minute-tens borrow: 10:00 -> 09:59
        key(4'd1);
        key(4'd0);
        key(4'd0);
        key(4'd0);
        press_start();
        tick();
        chk("m1_borrow", disp(), 16'h0959);
        press_cancel();
        press_cancel();

        // 4: door opens on the tick edge at 00:20
        key(4'd2);
        key(4'd0);
        press_start();
        tick_in   = 1'b1;
        door_open = 1'b1;
        step();
        chk("t4_pause_state", 16'(state), 16'd3);
        chk("t4_disp_held", disp(), 16'h0020);
        chk("t4_mag_off", 16'(mag_on), 16'd0);
        tick_in = 1'b0;
        step();
        press_start();
        chk("t4_start_door_open", 16'(state), 16'd3);
        door_open = 1'b0;
        tick();
        chk("t4_pause_ignores_tick", disp(), 16'h0020);
        press_start();
        chk("t4_resume", 16'({state, mag_on}), 16'({3'd2, 1'b1}));
        tick();
        chk("t4_resume_dec", disp(), 16'h0019);

        // Pause request stops RUN
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("pause_req", 16'({state, mag_on}), 16'({3'd3, 1'b0}));
        press_cancel();

        // 5: quick start, two cancels, door-open start
        press_start();
        chk("t5_quick_disp", disp(), 16'h0030);
        chk("t5_quick_run", 16'(state), 16'd2);
        press_cancel();
        chk("t5_cancel1", 16'(state), 16'd3);
        chk("t5_cancel1_disp", disp(), 16'h0030);
        press_cancel();
        chk("t5_cancel2", 16'(state), 16'd0);
        chk("t5_cancel2_disp", disp(), 16'h0000);
        door_open = 1'b1;
        press_start();
        chk("t5_door_start", 16'({state, mag_on}), 16'd0);
        door_open = 1'b0;

        // 6: asynchronous reset mid-RUN at 02:10
        key(4'd2);
        key(4'd1);
        key(4'd0);
        press_start();
        chk("t6_run", disp(), 16'h0210);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_mag", 16'(mag_on), 16'd0);
        chk("t6_async_disp", disp(), 16'h0000);
        chk("t6_async_state", 16'(state), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        tick();
        chk("t6_tick_no_change", disp(), 16'h0000);
        chk("t6_state_idle", 16'(state), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
